sdreq_mem_responder: RTL and testbench
======================================

Name: sdreq_mem_responder

Overview:
- Lower-level (L2/memory-side) responder for the cache's snoop-downstream request channel.
- Accepts sdreq transactions (RD, RFO, INV, WB), services them against a local line-granular backing store, and returns sursp responses (OKAY/FETCH/SNOOP/ERROR) using the shared cache package encodings.
- Includes a peer-snoop input so cache-to-cache forwarding (SURSP_SNOOP) can be exercised.
- Serves as the bus end of the cache's downstream interface in block and top-chip benches.

Parameters:
- ADDR_WIDTH, 32, width of sdreq_addr (line address)
- DATA_WIDTH, 32, width of one line of data
- MEM_DEPTH, 16, number of lines in the backing store; valid addresses 0..MEM_DEPTH-1
- RD_LATENCY, 2, cycles spent in WAIT per request; legal values are >=1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sdreq_valid  in  1  request valid
- sdreq_ready  out  1  responder can accept
- sdreq_op  in  3  SDREQ_RD/RFO/INV/WB encoding
- sdreq_addr  in  ADDR_WIDTH  line address
- sdreq_data  in  DATA_WIDTH  writeback data, WB only
- snp_hit  in  1  peer cache holds the line modified; sampled at accept
- snp_data  in  DATA_WIDTH  peer line data; sampled at accept
- sursp_valid  out  1  response valid
- sursp_ready  in  1  response consumed
- sursp_rsp  out  3  SURSP_OKAY/FETCH/SNOOP/ERROR encoding
- sursp_data  out  DATA_WIDTH  response data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - sdreq_ready=0 while rst=1.
  - sursp_valid=0, sursp_rsp=SURSP_OKAY, sursp_data=0.
  - FSM goes to IDLE, latency counter=0, all MEM_DEPTH lines cleared to 0.
- States:
  - IDLE: sdreq_ready=1. On sdreq_valid&sdreq_ready in cycle T, capture op, addr, data, snp_hit and snp_data, then go to WAIT.
  - WAIT: sdreq_ready=0. Counter runs 1..RD_LATENCY; go to RSP after RD_LATENCY cycles (cycles T+1..T+RD_LATENCY).
  - RSP: sursp_valid=1 from cycle T+RD_LATENCY+1. Hold sursp_rsp and sursp_data stable until sursp_valid&sursp_ready, then return to IDLE. sdreq_ready=1 on the following cycle.
- Timing rules:
  - No request overlap; one transaction in flight.
  - Minimum spacing between accepts is RD_LATENCY+2 cycles.
- Decode, evaluated on captured values:
  - op in {3'b100..3'b111}, or addr>=MEM_DEPTH: rsp=SURSP_ERROR, data=0, no state change.
  - RD, snp_hit=0: rsp=SURSP_FETCH, data=mem[addr].
  - RD, snp_hit=1: rsp=SURSP_SNOOP, data=captured snp_data. mem[addr] <= snp_data on the last WAIT cycle (M->S flush).
  - RFO, snp_hit=0: rsp=SURSP_FETCH, data=mem[addr].
  - RFO, snp_hit=1: rsp=SURSP_SNOOP, data=snp_data; mem unchanged (ownership transfers).
  - INV: rsp=SURSP_OKAY, data=0, mem unchanged.
  - WB: mem[addr] <= captured sdreq_data at the end of cycle T+1. rsp=SURSP_OKAY, data=0.
- Read data is taken from mem at the end of WAIT. A WB followed by RD to the same line always returns the written value.
- Address index uses addr[$clog2(MEM_DEPTH)-1:0] only after the range check passes. Upper bits are never silently truncated.
- Inputs ignored outside the accept cycle:
  - sdreq_valid while sdreq_ready=0.
  - sdreq_* and snp_* changing during WAIT/RSP.
- sursp_ready held high with no response pending has no effect.
- Reset mid-transaction, in WAIT or RSP: next cycle is IDLE with sursp_valid=0. The pending response is dropped and the memory is cleared.

Test Plan:
- Reset then RD addr 3 (MEM_DEPTH=16, RD_LATENCY=2), accepted at T -> sursp_valid first high at T+3, rsp=FETCH(3'b001), data=0; sdreq_ready low T+1..T+3.
- WB addr 5 data 32'hDEADBEEF, then RD addr 5 -> WB rsp=OKAY, data=0; RD rsp=FETCH, data=32'hDEADBEEF.
- RD addr 7 with snp_hit=1, snp_data=32'hCAFE0001, then RD addr 7 with snp_hit=0 -> first rsp=SNOOP(3'b010) data=32'hCAFE0001; second rsp=FETCH data=32'hCAFE0001. Repeat with RFO + snp_hit -> later FETCH returns prior mem value.
- RD addr 16, and op 3'b101 to addr 0 -> both rsp=ERROR(3'b011), data=0, mem unchanged.
- Hold sursp_ready=0 for 5 cycles in RSP -> sursp_valid/rsp/data stable throughout; new sdreq_valid not accepted until the cycle after the handshake.
- Assert rst during WAIT of a WB to addr 2 -> sursp_valid never rises, sdreq_ready=1 after reset deasserts, RD addr 2 returns data=0.

Source files
------------

// File: rtl/sdreq_mem_responder.sv
// ============================================================================
// Module   : sdreq_mem_responder
// Brief    : Memory-side responder for the sdreq/sursp channel. It serves
//            each request from a line-granular backing store and can forward
//            data from a snooping peer cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdreq_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdreq_valid,
    output logic                  sdreq_ready,
    input  logic [2:0]            sdreq_op,
    input  logic [ADDR_WIDTH-1:0] sdreq_addr,
    input  logic [DATA_WIDTH-1:0] sdreq_data,
    input  logic                  snp_hit,
    input  logic [DATA_WIDTH-1:0] snp_data,
    output logic                  sursp_valid,
    input  logic                  sursp_ready,
    output logic [2:0]            sursp_rsp,
    output logic [DATA_WIDTH-1:0] sursp_data
);

    localparam logic [2:0] c_SDREQ_RD   = 3'b000;
    localparam logic [2:0] c_SDREQ_RFO  = 3'b001;
    localparam logic [2:0] c_SDREQ_INV  = 3'b010;
    localparam logic [2:0] c_SDREQ_WB   = 3'b011;
    localparam logic [2:0] c_SURSP_OKAY  = 3'b000;
    localparam logic [2:0] c_SURSP_FETCH = 3'b001;
    localparam logic [2:0] c_SURSP_SNOOP = 3'b010;
    localparam logic [2:0] c_SURSP_ERROR = 3'b011;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0]      c_CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0]      c_CNT_LAST  = CNT_W'(RD_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LIM  = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    hit_q, hit_d;
    logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
    logic [2:0]              rsp_q, rsp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    w_accept;
    logic                    w_err;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_mem_we;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    assign sdreq_ready = (state_q == ST_IDLE) && !rst;
    assign sursp_valid = (state_q == ST_RSP) && !rst;
    assign sursp_rsp   = rsp_q;
    assign sursp_data  = rdata_q;
    assign w_accept    = sdreq_valid && sdreq_ready;

    // The full captured address is range-checked, so an out-of-range address never aliases a real line.
    assign w_err = op_q[2] || (addr_q >= c_ADDR_LIM);
    assign w_idx = addr_q[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        sdata_d     = sdata_q;
        rsp_d       = rsp_q;
        rdata_d     = rdata_q;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d    = sdreq_op;
                    addr_d  = sdreq_addr;
                    wdata_d = sdreq_data;
                    hit_d   = snp_hit;
                    sdata_d = snp_data;
                    cnt_d   = c_CNT_FIRST;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_err && op_q == c_SDREQ_WB && cnt_q == c_CNT_FIRST) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = wdata_q;
                end
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RSP;
                    rsp_d   = c_SURSP_OKAY;
                    rdata_d = '0;
                    if (w_err) begin
                        rsp_d = c_SURSP_ERROR;
                    end else if (op_q == c_SDREQ_RD || op_q == c_SDREQ_RFO) begin
                        if (hit_q) begin
                            rsp_d   = c_SURSP_SNOOP;
                            rdata_d = sdata_q;
                            // A read snoop downgrades the peer's modified copy to shared, so memory takes the flush.
                            if (op_q == c_SDREQ_RD) begin
                                w_mem_we    = 1'b1;
                                w_mem_wdata = sdata_q;
                            end
                        end else begin
                            rsp_d   = c_SURSP_FETCH;
                            rdata_d = mem_q[w_idx];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (sursp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= c_SDREQ_INV;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            sdata_q <= '0;
            rsp_q   <= c_SURSP_OKAY;
            rdata_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            sdata_q <= sdata_d;
            rsp_q   <= rsp_d;
            rdata_q <= rdata_d;
            if (w_mem_we) begin
                mem_q[w_idx] <= w_mem_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdreq_mem_responder.sv
// ============================================================================
// Module   : tb_sdreq_mem_responder
// Brief    : Directed self-checking bench for sdreq_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdreq_mem_responder;

    logic        clk;
    logic        rst;
    logic        sdreq_valid;
    logic        sdreq_ready;
    logic [2:0]  sdreq_op;
    logic [31:0] sdreq_addr;
    logic [31:0] sdreq_data;
    logic        snp_hit;
    logic [31:0] snp_data;
    logic        sursp_valid;
    logic        sursp_ready;
    logic [2:0]  sursp_rsp;
    logic [31:0] sursp_data;

    int tests;
    int fails;

    logic [2:0]  r_rsp;
    logic [31:0] r_dat;

    sdreq_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (16),
        .RD_LATENCY (2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sdreq_valid (sdreq_valid),
        .sdreq_ready (sdreq_ready),
        .sdreq_op    (sdreq_op),
        .sdreq_addr  (sdreq_addr),
        .sdreq_data  (sdreq_data),
        .snp_hit     (snp_hit),
        .snp_data    (snp_data),
        .sursp_valid (sursp_valid),
        .sursp_ready (sursp_ready),
        .sursp_rsp   (sursp_rsp),
        .sursp_data  (sursp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge with the DUT idle. While the request is in
    // flight, a conflicting WB to line 9 is presented to show it is ignored.
    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic hit, input logic [31:0] sd, input int hold,
                       output logic [2:0] rsp, output logic [31:0] rdat);
        int lat;
        logic [2:0]  hrsp;
        logic [31:0] hdat;
        check("ready_before_req", {31'd0, sdreq_ready}, 32'd1);
        sdreq_valid = 1'b1;
        sdreq_op    = op;
        sdreq_addr  = addr;
        sdreq_data  = wdata;
        snp_hit     = hit;
        snp_data    = sd;
        sursp_ready = 1'b0;
        @(negedge clk);
        sdreq_op    = 3'b011;
        sdreq_addr  = 32'd9;
        sdreq_data  = 32'h9999_9999;
        snp_hit     = ~hit;
        snp_data    = $urandom;
        lat = 1;
        while (!sursp_valid && lat < 20) begin
            check("ready_low_wait", {31'd0, sdreq_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", lat, 32'd3);
        check("ready_low_rsp", {31'd0, sdreq_ready}, 32'd0);
        rsp  = sursp_rsp;
        rdat = sursp_data;
        hrsp = sursp_rsp;
        hdat = sursp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            snp_data = $urandom;
            check("hold_valid", {31'd0, sursp_valid}, 32'd1);
            check("hold_rsp", {29'd0, sursp_rsp}, {29'd0, hrsp});
            check("hold_data", sursp_data, hdat);
            check("hold_ready_low", {31'd0, sdreq_ready}, 32'd0);
        end
        sursp_ready = 1'b1;
        @(negedge clk);
        sdreq_valid = 1'b0;
        sursp_ready = 1'b0;
        check("valid_drop_after_hs", {31'd0, sursp_valid}, 32'd0);
        check("ready_after_hs", {31'd0, sdreq_ready}, 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input logic [2:0] rsp, input logic [31:0] dat,
                              input logic [2:0] exp_rsp, input logic [31:0] exp_dat);
        check({tag, "_rsp"}, {29'd0, rsp}, {29'd0, exp_rsp});
        check({tag, "_data"}, dat, exp_dat);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        sdreq_valid = 1'b1;
        sdreq_op    = 3'b000;
        sdreq_addr  = 32'd0;
        sdreq_data  = 32'd0;
        snp_hit     = 1'b0;
        snp_data    = 32'd0;
        sursp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, sdreq_ready}, 32'd0);
        check("reset_valid", {31'd0, sursp_valid}, 32'd0);
        check("reset_rsp", {29'd0, sursp_rsp}, 32'd0);
        check("reset_data", sursp_data, 32'd0);
        sdreq_valid = 1'b0;
        rst         = 1'b0;
        sursp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_rdy_no_rsp", {31'd0, sursp_valid}, 32'd0);

        txn(3'b000, 32'd3, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd3", r_rsp, r_dat, 3'b001, 32'd0);

        txn(3'b011, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("wb5", r_rsp, r_dat, 3'b000, 32'd0);
        txn(3'b000, 32'd5, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd5", r_rsp, r_dat, 3'b001, 32'hDEAD_BEEF);

        txn(3'b000, 32'd7, 32'd0, 1'b1, 32'hCAFE_0001, 0, r_rsp, r_dat);
        expect_rsp("rd7_snoop", r_rsp, r_dat, 3'b010, 32'hCAFE_0001);
        txn(3'b000, 32'd7, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd7_flushed", r_rsp, r_dat, 3'b001, 32'hCAFE_0001);
        txn(3'b001, 32'd7, 32'd0, 1'b1, 32'h0BAD_F00D, 0, r_rsp, r_dat);
        expect_rsp("rfo7_snoop", r_rsp, r_dat, 3'b010, 32'h0BAD_F00D);
        txn(3'b000, 32'd7, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd7_after_rfo", r_rsp, r_dat, 3'b001, 32'hCAFE_0001);
        txn(3'b001, 32'd5, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rfo5_fetch", r_rsp, r_dat, 3'b001, 32'hDEAD_BEEF);

        txn(3'b000, 32'd16, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd16_err", r_rsp, r_dat, 3'b011, 32'd0);
        txn(3'b101, 32'd0, 32'h5555_AAAA, 1'b1, 32'h1234_5678, 0, r_rsp, r_dat);
        expect_rsp("op5_err", r_rsp, r_dat, 3'b011, 32'd0);
        txn(3'b011, 32'h1000_0003, 32'h7777_7777, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("wb_hiaddr_err", r_rsp, r_dat, 3'b011, 32'd0);
        txn(3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd0_unchanged", r_rsp, r_dat, 3'b001, 32'd0);
        txn(3'b000, 32'd3, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd3_no_alias", r_rsp, r_dat, 3'b001, 32'd0);
        txn(3'b000, 32'd15, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd15_edge", r_rsp, r_dat, 3'b001, 32'd0);

        txn(3'b010, 32'd5, 32'h1111_1111, 1'b1, 32'h2222_2222, 0, r_rsp, r_dat);
        expect_rsp("inv5", r_rsp, r_dat, 3'b000, 32'd0);
        txn(3'b000, 32'd5, 32'd0, 1'b0, 32'd0, 5, r_rsp, r_dat);
        expect_rsp("rd5_hold", r_rsp, r_dat, 3'b001, 32'hDEAD_BEEF);
        txn(3'b000, 32'd9, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd9_ignored_wb", r_rsp, r_dat, 3'b001, 32'd0);

        sdreq_valid = 1'b1;
        sdreq_op    = 3'b011;
        sdreq_addr  = 32'd2;
        sdreq_data  = 32'h1234_5678;
        @(negedge clk);
        sdreq_valid = 1'b0;
        rst         = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_valid", {31'd0, sursp_valid}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_valid", {31'd0, sursp_valid}, 32'd0);
            @(negedge clk);
        end
        check("post_rst_ready", {31'd0, sdreq_ready}, 32'd1);
        txn(3'b000, 32'd2, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd2_after_rst", r_rsp, r_dat, 3'b001, 32'd0);
        txn(3'b000, 32'd5, 32'd0, 1'b0, 32'd0, 0, r_rsp, r_dat);
        expect_rsp("rd5_cleared", r_rsp, r_dat, 3'b001, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
